lsu_thread_port: RTL and testbench

- Per-thread load/store unit: the read side of the per-thread register file and the producer of its MEMORY write-back input.
- Consumes the rs/rt operands latched in REQUEST.
- Runs a valid/ready transaction on the data-memory port and returns loaded data on lsu_out for write-back in UPDATE.
- One instance per thread per core, sitting between the register file and the core's memory controller channel.

---
 rtl/lsu_thread_port.sv | 182 ++++++++++++++++++
 tb/tb_lsu_thread_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_thread_port.sv
// Per-thread load/store unit.
// Reads the rs/rt operands that the register file latched in REQUEST and runs
// one valid/ready transaction on the data-memory port. Loaded data is returned
// on lsu_out for write-back in UPDATE.
// Optional feature: define LSU_TIMEOUT_EN to add a WAITING watchdog. When it
// fires, the unit abandons the transaction and raises lsu_error.
module lsu_thread_port #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [2:0] CS_REQUEST = 3'b011;
  localparam logic [2:0] CS_UPDATE  = 3'b110;

  state_t                 state_q, state_d;
  logic                   is_rd_q, is_rd_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                   wr_vld_q, wr_vld_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0]   out_q, out_d;
  logic [ADDR_BITS-1:0]   rs_addr;
  logic                   accept;

  // Address is rs resized to the memory width (truncate or zero-extend).
  if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
    assign rs_addr = rs[ADDR_BITS-1:0];
  end else begin : g_addr_ext
    assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
  end

  // Only the ready of the latched transaction type counts.
  assign accept = is_rd_q ? mem_read_ready : mem_write_ready;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Next-state and next-output logic. Everything holds while enable is low.
  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    rd_vld_d  = rd_vld_q;
    rd_addr_d = rd_addr_q;
    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    out_d     = out_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (core_state == CS_REQUEST &&
              (decoded_mem_read_enable || decoded_mem_write_enable)) begin
            // When both enables are set, the read takes priority.
            is_rd_d = decoded_mem_read_enable;
            state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (is_rd_q) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = rs_addr;
          end else begin
            wr_vld_d  = 1'b1;
            wr_addr_d = rs_addr;
            wr_data_d = rt;
          end
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (accept) begin
            rd_vld_d = 1'b0;
            wr_vld_d = 1'b0;
            if (is_rd_q) out_d = mem_read_data;
            state_d  = S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            rd_vld_d = 1'b0;
            wr_vld_d = 1'b0;
            err_d    = 1'b1;
            if (is_rd_q) out_d = {DATA_BITS{1'b1}};
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
        default: begin // S_DONE
          if (core_state == CS_UPDATE) state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register; synchronous reset overrides everything, including an
  // in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_rd_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_q     <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      out_q     <= out_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign lsu_state         = state_q;
  assign mem_read_valid    = rd_vld_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_vld_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_out           = out_q;
`ifdef LSU_TIMEOUT_EN
  assign lsu_error         = err_q;
`else
  assign lsu_error         = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_thread_port.sv
// Directed testbench for lsu_thread_port. Inputs are driven and outputs are
// checked 1ns after each rising edge.
module tb_lsu_thread_port;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_thread_port #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; enable = 1; core_state = 3'b000; rd_en = 0; wr_en = 0;
    rs = 0; rt = 0; mem_read_ready = 0; mem_read_data = 0; mem_write_ready = 0;
    tick(); tick();
    chk("rst_state", lsu_state, 2'b00);
    chk("rst_rvld", mem_read_valid, 0);
    chk("rst_wvld", mem_write_valid, 0);
    chk("rst_raddr", mem_read_address, 8'h00);
    chk("rst_waddr", mem_write_address, 8'h00);
    chk("rst_wdata", mem_write_data, 8'h00);
    chk("rst_out", lsu_out, 8'h00);
    chk("rst_err", lsu_error, 0);
    reset = 0;

    // Disabled IDLE with a request phase: nothing starts.
    enable = 0; rd_en = 1; core_state = 3'b011; rs = 8'h2A;
    tick();
    chk("dis_idle_state", lsu_state, 2'b00);
    enable = 1;

    // Load with three wait cycles.
    tick();
    chk("ld_req_state", lsu_state, 2'b01);
    chk("ld_req_vld", mem_read_valid, 0);
    core_state = 3'b000; rd_en = 0;
    tick();
    chk("ld_wait_state", lsu_state, 2'b10);
    chk("ld_vld", mem_read_valid, 1);
    chk("ld_addr", mem_read_address, 8'h2A);
    chk("ld_wvld", mem_write_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_hold_vld", mem_read_valid, 1);
      chk("ld_hold_state", lsu_state, 2'b10);
      chk("ld_hold_addr", mem_read_address, 8'h2A);
    end
    mem_read_ready = 1; mem_read_data = 8'h5C;
    tick();
    chk("ld_done_state", lsu_state, 2'b11);
    chk("ld_done_vld", mem_read_valid, 0);
    chk("ld_out", lsu_out, 8'h5C);
    chk("ld_err", lsu_error, 0);
    mem_read_ready = 0; mem_read_data = 8'h00;
    core_state = 3'b110;
    tick();
    chk("ld_idle", lsu_state, 2'b00);

    // Store accepted in the first cycle its valid is high.
    wr_en = 1; rs = 8'h10; rt = 8'h77; core_state = 3'b011;
    tick();
    chk("st_req_state", lsu_state, 2'b01);
    core_state = 3'b000; wr_en = 0;
    tick();
    chk("st_wvld", mem_write_valid, 1);
    chk("st_waddr", mem_write_address, 8'h10);
    chk("st_wdata", mem_write_data, 8'h77);
    chk("st_rvld", mem_read_valid, 0);
    mem_write_ready = 1;
    tick();
    chk("st_done_state", lsu_state, 2'b11);
    chk("st_done_wvld", mem_write_valid, 0);
    chk("st_out_kept", lsu_out, 8'h5C);
    mem_write_ready = 0; core_state = 3'b110;
    tick();
    chk("st_idle", lsu_state, 2'b00);

    // Both enables set: only the read is issued.
    rd_en = 1; wr_en = 1; rs = 8'h03; rt = 8'h99; core_state = 3'b011;
    tick();
    core_state = 3'b000; rd_en = 0; wr_en = 0;
    tick();
    chk("both_rvld", mem_read_valid, 1);
    chk("both_raddr", mem_read_address, 8'h03);
    chk("both_wvld", mem_write_valid, 0);
    mem_read_ready = 1; mem_read_data = 8'h41;
    tick();
    chk("both_state", lsu_state, 2'b11);
    chk("both_out", lsu_out, 8'h41);
    chk("both_wvld2", mem_write_valid, 0);
    mem_read_ready = 0;

    // DONE holds for every phase except UPDATE; a stray ready is ignored.
    for (int c = 0; c < 6; c++) begin
      core_state = 3'(c);
      mem_read_ready = (c == 2); mem_read_data = 8'hEE;
      rd_en = (c == 3);
      tick();
      chk("done_hold_state", lsu_state, 2'b11);
      chk("done_hold_out", lsu_out, 8'h41);
    end
    mem_read_ready = 0; rd_en = 0;
    core_state = 3'b110;
    tick();
    chk("done_to_idle", lsu_state, 2'b00);

    // New read, then freeze it in WAITING.
    rd_en = 1; rs = 8'h2A; core_state = 3'b011;
    tick();
    chk("re_req_state", lsu_state, 2'b01);
    core_state = 3'b000; rd_en = 0;
    tick();
    chk("re_wait_vld", mem_read_valid, 1);
    enable = 0; mem_read_ready = 1; mem_read_data = 8'h12;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_state", lsu_state, 2'b10);
      chk("frz_vld", mem_read_valid, 1);
      chk("frz_out", lsu_out, 8'h41);
    end
    enable = 1; mem_read_ready = 0; reset = 1;
    tick();
    chk("mid_rst_state", lsu_state, 2'b00);
    chk("mid_rst_vld", mem_read_valid, 0);
    chk("mid_rst_out", lsu_out, 8'h00);
    reset = 0;

`ifdef LSU_TIMEOUT_EN
    // Read with no ready: watchdog fires after four WAITING cycles.
    rd_en = 1; rs = 8'h20; core_state = 3'b011;
    tick();
    core_state = 3'b000; rd_en = 0;
    tick();
    chk("to_vld", mem_read_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_state", lsu_state, 2'b10);
      chk("to_wait_vld", mem_read_valid, 1);
    end
    tick();
    chk("to_state", lsu_state, 2'b11);
    chk("to_vld_drop", mem_read_valid, 0);
    chk("to_err", lsu_error, 1);
    chk("to_out", lsu_out, 8'hFF);
    mem_read_ready = 1; mem_read_data = 8'h33;
    tick();
    chk("to_late_out", lsu_out, 8'hFF);
    mem_read_ready = 0; core_state = 3'b110;
    tick();
    chk("to_idle", lsu_state, 2'b00);
    rd_en = 1; core_state = 3'b011;
    tick();
    chk("to_err_clr", lsu_error, 0);
    chk("to_new_req", lsu_state, 2'b01);
    rd_en = 0; core_state = 3'b000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
